// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// 640x480@60 Hz raster timing generator running on the 25 MHz pixel clock.
// DrawX/DrawY are the live (registered) pixel/line counters that feed every
// sprite/ROM stage. Sprite stages take two cycles from DrawX/DrawY to
// registered RGB: one for the ROM read and one for the output register.
// blank is therefore delayed by BLANK_DLY and hs/vs by SYNC_DLY, so they line
// up with the pixel data that leaves the sprite pipeline.
//
// Optional feature (compile-time macro):
//   VGA_FRAME_COUNT_EN  defined   -> frame_count counts completed frames
//                                    (wraps 255 -> 0)
//                       undefined -> frame_count is tied to 8'h00 and no
//                                    counter register is built
//
// Ports:
//   vga_clk      in   1   pixel clock, 25 MHz
//   reset        in   1   synchronous, active-high
//   DrawX        out  10  pixel column counter, 0..H_TOTAL-1
//   DrawY        out  10  line counter, 0..V_TOTAL-1
//   blank        out  1   1 = visible pixel, 0 = blanking (lags BLANK_DLY)
//   hs           out  1   horizontal sync, active-low (lags SYNC_DLY)
//   vs           out  1   vertical sync, active-low (lags SYNC_DLY)
//   sync         out  1   composite sync, constant 0
//   frame_start  out  1   one-cycle pulse at DrawX=0, DrawY=0 (undelayed)
//   frame_count  out  8   frames completed
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int BLANK_DLY = 1,
    parameter int SYNC_DLY  = 2
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       sync,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       v_wrap;
    logic       vis;
    logic       hs_raw;
    logic       vs_raw;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Raster counters: the line counter only moves on the pixel wrap.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign DrawX = h_cnt;
    assign DrawY = v_cnt;

    // Undelayed decodes of the registered counters.
    assign vis    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));

    assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign sync        = 1'b0;

    // blank delay line; idles at 0 so reset never shows a visible pixel.
    generate
        if (BLANK_DLY == 0) begin : g_blank_comb
            assign blank = vis;
        end else begin : g_blank_pipe
            logic [BLANK_DLY-1:0] blank_pipe;
            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    blank_pipe <= '0;
                end else begin
                    blank_pipe[0] <= vis;
                    for (int i = 1; i < BLANK_DLY; i++) begin
                        blank_pipe[i] <= blank_pipe[i-1];
                    end
                end
            end
            assign blank = blank_pipe[BLANK_DLY-1];
        end
    endgenerate

    // Sync delay lines; idle high so a reset flushes any partial pulse.
    generate
        if (SYNC_DLY == 0) begin : g_sync_comb
            assign hs = hs_raw;
            assign vs = vs_raw;
        end else begin : g_sync_pipe
            logic [SYNC_DLY-1:0] hs_pipe;
            logic [SYNC_DLY-1:0] vs_pipe;
            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    hs_pipe <= '1;
                    vs_pipe <= '1;
                end else begin
                    hs_pipe[0] <= hs_raw;
                    vs_pipe[0] <= vs_raw;
                    for (int i = 1; i < SYNC_DLY; i++) begin
                        hs_pipe[i] <= hs_pipe[i-1];
                        vs_pipe[i] <= vs_pipe[i-1];
                    end
                end
            end
            assign hs = hs_pipe[SYNC_DLY-1];
            assign vs = vs_pipe[SYNC_DLY-1];
        end
    endgenerate

`ifdef VGA_FRAME_COUNT_EN
    // Steps on the last pixel of the frame, so the new value is visible
    // together with frame_start of the following frame.
    logic [7:0] frame_cnt_q;
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (h_wrap && v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end
    assign frame_count = frame_cnt_q;
`else
    assign frame_count = 8'h00;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// Bench for vga_timing_gen. Two instances share clock and reset: one with the
// real 640x480 timing (line-level behaviour) and one with a shrunken raster
// (15 x 8 = 120 cycles per frame) so vertical sync, frame_start, frame_count
// wrap and mid-sync reset can be exercised in a short run.
// Expected outputs come from a closed-form model of the raster position:
// n = cycles since the last reset edge, x = n mod H_TOTAL, y = n div H_TOTAL
// mod V_TOTAL, with blank/sync taken from the position 1/2 cycles earlier.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int BLANK_DLY = 1;
  localparam int SYNC_DLY  = 2;
  localparam int SF        = 120;  // small-raster frame length
`ifdef VGA_FRAME_COUNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  always #20 vga_clk = ~vga_clk;

  logic [9:0] f_x, f_y, s_x, s_y;
  logic       f_blank, f_hs, f_vs, f_sync, f_fs;
  logic       s_blank, s_hs, s_vs, s_sync, s_fs;
  logic [7:0] f_fc, s_fc;

  vga_timing_gen u_dut_full (
    .vga_clk(vga_clk), .reset(reset), .DrawX(f_x), .DrawY(f_y),
    .blank(f_blank), .hs(f_hs), .vs(f_vs), .sync(f_sync),
    .frame_start(f_fs), .frame_count(f_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_dut_small (
    .vga_clk(vga_clk), .reset(reset), .DrawX(s_x), .DrawY(s_y),
    .blank(s_blank), .hs(s_hs), .vs(s_vs), .sync(s_sync),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int n      = 0;
  logic [33:0] exp_full_q[$];
  logic [33:0] exp_small_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  // Packed as {frame_count, frame_start, vs, hs, blank, DrawY, DrawX}.
  function automatic logic [33:0] exp_vec(input int cyc, input int hv, input int hfp,
                                          input int hsw, input int hbp, input int vv,
                                          input int vfp, input int vsw, input int vbp);
    int ht, vt, x, y, pb, ps, xb, yb, xs, ys;
    logic b, h, v, fs;
    logic [7:0] fc;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    x  = cyc % ht;
    y  = (cyc / ht) % vt;
    pb = cyc - BLANK_DLY;
    ps = cyc - SYNC_DLY;
    b  = 1'b0;
    h  = 1'b1;
    v  = 1'b1;
    if (pb >= 0) begin
      xb = pb % ht;
      yb = (pb / ht) % vt;
      b  = (xb < hv) && (yb < vv);
    end
    if (ps >= 0) begin
      xs = ps % ht;
      ys = (ps / ht) % vt;
      h  = !((xs >= hv + hfp) && (xs < hv + hfp + hsw));
      v  = !((ys >= vv + vfp) && (ys < vv + vfp + vsw));
    end
    fs = (x == 0) && (y == 0);
    fc = FC_EN ? 8'((cyc / (ht * vt)) % 256) : 8'h00;
    return {fc, fs, v, h, b, 10'(y), 10'(x)};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge: drive reset, predict, clock once, compare at next negedge.
  task automatic step(input logic r);
    reset = r;
    n = r ? 0 : n + 1;
    exp_full_q.push_back(exp_vec(n, 640, 16, 96, 48, 480, 10, 2, 33));
    exp_small_q.push_back(exp_vec(n, 8, 2, 3, 2, 4, 1, 2, 1));
    @(posedge vga_clk);
    @(negedge vga_clk);
    check("full_vec", {f_fc, f_fs, f_vs, f_hs, f_blank, f_y, f_x}, exp_full_q.pop_front());
    check("small_vec", {s_fc, s_fs, s_vs, s_hs, s_blank, s_y, s_x}, exp_small_q.pop_front());
  endtask

  int hs_low, first_hs, blank_cnt, first_blank, last_blank;
  int vs_low, fs_cnt, sblank_cnt;

  initial begin
    @(negedge vga_clk);

    // Reset held 3 cycles: state seen in the first cycle after release.
    repeat (3) step(1'b1);
    check("rst_drawxy", {f_y, f_x}, 20'd0);
    check("rst_frame_start", f_fs, 1'b1);
    check("rst_blank", f_blank, 1'b0);
    check("rst_hs_vs", {f_hs, f_vs}, 2'b11);
    check("rst_frame_count", f_fc, 8'h00);

    // One full line of the real raster.
    hs_low = 0; first_hs = -1; blank_cnt = 0; first_blank = -1; last_blank = -1;
    for (int i = 0; i < 800; i++) begin
      step(1'b0);
      if (!f_hs) begin
        hs_low++;
        if (first_hs < 0) first_hs = int'(f_x);
      end
      if (f_blank) begin
        blank_cnt++;
        if (first_blank < 0) first_blank = int'(f_x);
        last_blank = int'(f_x);
      end
    end
    check("line_wrap_x", f_x, 10'd0);
    check("line_wrap_y", f_y, 10'd1);
    check("hs_low_len", hs_low, 96);
    check("hs_first_low_x", first_hs, 658);
    check("blank_count", blank_cnt, 640);
    check("blank_first_x", first_blank, 1);
    check("blank_last_x", last_blank, 640);

    // Small raster: many frames, frame_count wrap, per-frame counts.
    vs_low = 0; fs_cnt = 0; sblank_cnt = 0;
    while (n < 257 * SF) begin
      step(1'b0);
      if (n >= 10 * SF && n < 11 * SF) begin
        if (!s_vs) vs_low++;
        if (s_fs) fs_cnt++;
        if (s_blank) sblank_cnt++;
      end
      if (n == 11 * SF)  check("fc_frame10", s_fc, FC_EN ? 8'd11 : 8'd0);
      if (n == 255 * SF) check("fc_frame255", s_fc, FC_EN ? 8'd255 : 8'd0);
      if (n == 256 * SF) check("fc_wrap256", s_fc, 8'd0);
      if (n == 257 * SF) check("fc_frame257", s_fc, FC_EN ? 8'd1 : 8'd0);
    end
    check("vs_low_per_frame", vs_low, 2 * 15);
    check("frame_start_per_frame", fs_cnt, 1);
    check("blank_per_frame", sblank_cnt, 8 * 4);

    // Move to x=12, y=6 of the small raster: both syncs low, then reset.
    for (int i = 0; i < SF && (n % SF) != 6 * 15 + 12; i++) step(1'b0);
    check("pre_rst_pos", {s_y, s_x}, {10'd6, 10'd12});
    check("pre_rst_sync_low", {s_hs, s_vs}, 2'b00);
    step(1'b1);
    check("mid_rst_pos", {s_y, s_x}, 20'd0);
    check("mid_rst_sync_idle", {s_hs, s_vs}, 2'b11);
    first_hs = -1;
    for (int i = 0; i < 15; i++) begin
      step(1'b0);
      if (!s_hs && first_hs < 0) first_hs = int'(s_x);
    end
    check("post_rst_first_hs_x", first_hs, 12);
    check("sync_const", {f_sync, s_sync}, 2'b00);
    check("queues_drained", exp_full_q.size() + exp_small_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
